// File: rtl/inst_decode_pipe.sv
// Decode stage with integrated 32-entry register file, valid/ready handshake on both sides,
// write-back bypass into operand reads, flush, and a registered decode packet.
module inst_decode_pipe #(
    parameter int XLEN   = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] store_data,
    output logic            write_back,
    output logic            mem_acc,
    output logic            load_flag,
    output logic            store_flag,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] store_data;
        logic            write_back;
        logic            mem_acc;
        logic            load_flag;
        logic            store_flag;
        logic            illegal;
    } pkt_t;

    logic [XLEN-1:0] regs_reg [32];
    pkt_t            pkt_reg;
    pkt_t            pkt_next;
    logic            valid_reg;
    logic            load;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;

    assign rd_f  = inst[11:7];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));

    assign in_ready = !valid_reg || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Entry 0 is reset to zero and never written, so x0 reads as zero without a special case.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs_reg[wb_rd] <= wb_value;
        end
    end

    always_comb begin
        rs1_val = regs_reg[rs1_f];
        rs2_val = regs_reg[rs2_f];
        if (BYPASS && wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_f)) begin
            rs1_val = wb_value;
        end
        if (BYPASS && wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_f)) begin
            rs2_val = wb_value;
        end
    end

    // Fields an opcode does not use stay at zero so no stale value leaks into the packet.
    always_comb begin
        pkt_next = '0;
        case (inst[6:0])
            OPC_OP: begin
                pkt_next.rd         = rd_f;
                pkt_next.rs1        = rs1_f;
                pkt_next.rs2        = rs2_f;
                pkt_next.funct3     = inst[14:12];
                pkt_next.funct7     = inst[31:25];
                pkt_next.op1        = rs1_val;
                pkt_next.op2        = rs2_val;
                pkt_next.write_back = 1'b1;
            end
            OPC_OP_IMM: begin
                pkt_next.rd         = rd_f;
                pkt_next.rs1        = rs1_f;
                pkt_next.funct3     = inst[14:12];
                pkt_next.funct7     = inst[31:25];
                pkt_next.imm        = imm_i;
                pkt_next.op1        = rs1_val;
                pkt_next.op2        = imm_i;
                pkt_next.write_back = 1'b1;
            end
            OPC_LOAD: begin
                pkt_next.rd         = rd_f;
                pkt_next.rs1        = rs1_f;
                pkt_next.funct3     = inst[14:12];
                pkt_next.imm        = imm_i;
                pkt_next.op1        = rs1_val;
                pkt_next.op2        = imm_i;
                pkt_next.mem_acc    = 1'b1;
                pkt_next.load_flag  = 1'b1;
                pkt_next.write_back = 1'b1;
            end
            OPC_STORE: begin
                pkt_next.rs1        = rs1_f;
                pkt_next.rs2        = rs2_f;
                pkt_next.funct3     = inst[14:12];
                pkt_next.imm        = imm_s;
                pkt_next.op1        = rs1_val;
                pkt_next.op2        = imm_s;
                pkt_next.store_data = rs2_val;
                pkt_next.mem_acc    = 1'b1;
                pkt_next.store_flag = 1'b1;
            end
            OPC_LUI: begin
                pkt_next.rd         = rd_f;
                pkt_next.imm        = imm_u;
                pkt_next.op2        = imm_u;
                pkt_next.write_back = 1'b1;
            end
            OPC_AUIPC: begin
                pkt_next.rd         = rd_f;
                pkt_next.imm        = imm_u;
                pkt_next.op1        = pc;
                pkt_next.op2        = imm_u;
                pkt_next.write_back = 1'b1;
            end
            default: begin
                pkt_next.illegal    = 1'b1;
            end
        endcase
    end

    // Flush beats both a new load and a plain consume.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            pkt_reg   <= '0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (load) begin
                valid_reg <= 1'b1;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
            if (load) begin
                pkt_reg <= pkt_next;
            end
        end
    end

    assign out_valid  = valid_reg;
    assign rd         = pkt_reg.rd;
    assign rs1        = pkt_reg.rs1;
    assign rs2        = pkt_reg.rs2;
    assign funct3     = pkt_reg.funct3;
    assign funct7     = pkt_reg.funct7;
    assign imm        = pkt_reg.imm;
    assign op1        = pkt_reg.op1;
    assign op2        = pkt_reg.op2;
    assign store_data = pkt_reg.store_data;
    assign write_back = pkt_reg.write_back;
    assign mem_acc    = pkt_reg.mem_acc;
    assign load_flag  = pkt_reg.load_flag;
    assign store_flag = pkt_reg.store_flag;
    assign illegal    = pkt_reg.illegal;

endmodule
